// File: rtl/alu_cmd_issuer_pkg.sv
// Shared definitions for the ALU command issuer: unit-select codes and
// the issuer state encoding.
package alu_issuer_pkg;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } issuer_state_t;

  // Extract the unit-select field from an ALU function code.
  function automatic logic [1:0] unit_of(input logic [3:0] fun);
    return fun[3:2];
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command/response handshake bundle between a host front end (master)
// and the ALU command issuer (slave).
interface alu_cmd_issuer_if #(
  parameter int Op_Width = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [Op_Width-1:0] cmd_a;
  logic [Op_Width-1:0] cmd_b;
  logic [3:0]          cmd_fun;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [Op_Width-1:0] rsp_data;
  logic                rsp_carry;
  logic [1:0]          rsp_unit;
  logic                rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_fun, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_unit, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_fun, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_unit, rsp_err
  );
endinterface

// File: rtl/alu_cmd_issuer_rsp_mux.sv
// Combinational selection of an ALU unit's result, valid flag and carry
// by unit code. Carry is meaningful only for the arithmetic unit.
module alu_rsp_mux
  import alu_issuer_pkg::*;
#(
  parameter int Op_Width = 16
) (
  input  logic [1:0]          unit,
  input  logic [Op_Width-1:0] arith_out,
  input  logic [Op_Width-1:0] logic_out,
  input  logic [Op_Width-1:0] cmp_out,
  input  logic [Op_Width-1:0] shift_out,
  input  logic                carry_out,
  input  logic                arith_flag,
  input  logic                logic_flag,
  input  logic                cmp_flag,
  input  logic                shift_flag,
  output logic [Op_Width-1:0] sel_data,
  output logic                sel_flag,
  output logic                sel_carry
);

  // Route the selected unit's result and flag; carry only for arithmetic.
  always_comb begin
    sel_data  = '0;
    sel_flag  = 1'b0;
    sel_carry = 1'b0;
    case (unit)
      UNIT_ARITH: begin
        sel_data  = arith_out;
        sel_flag  = arith_flag;
        sel_carry = carry_out;
      end
      UNIT_LOGIC: begin
        sel_data = logic_out;
        sel_flag = logic_flag;
      end
      UNIT_CMP: begin
        sel_data = cmp_out;
        sel_flag = cmp_flag;
      end
      default: begin
        sel_data = shift_out;
        sel_flag = shift_flag;
      end
    endcase
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: accepts one command per handshake, drives the ALU
// operand/function inputs from registers, waits for the selected unit's
// flag and returns the captured result on the response port.
// Optional macro ALU_ISSUER_TIMEOUT_EN bounds the wait to TIMEOUT_CYC
// cycles and returns an error response when the bound expires.
module alu_cmd_issuer
  import alu_issuer_pkg::*;
#(
  parameter int Op_Width    = 16,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                CLK,
  input  logic                RST,
  alu_cmd_issuer_if.slave     bus,
  output logic [Op_Width-1:0] alu_a,
  output logic [Op_Width-1:0] alu_b,
  output logic [3:0]          alu_fun,
  input  logic [Op_Width-1:0] arith_out,
  input  logic [Op_Width-1:0] logic_out,
  input  logic [Op_Width-1:0] cmp_out,
  input  logic [Op_Width-1:0] shift_out,
  input  logic                carry_out,
  input  logic                arith_flag,
  input  logic                logic_flag,
  input  logic                cmp_flag,
  input  logic                shift_flag
);

  issuer_state_t       state_q;
  issuer_state_t       state_d;
  logic                load_cmd;
  logic                capture;
  logic [Op_Width-1:0] sel_data;
  logic                sel_flag;
  logic                sel_carry;
  logic [Op_Width-1:0] rsp_data_q;
  logic                rsp_carry_q;
  logic [1:0]          rsp_unit_q;

  alu_rsp_mux #(
    .Op_Width(Op_Width)
  ) u_rsp_mux (
    .unit       (unit_of(alu_fun)),
    .arith_out  (arith_out),
    .logic_out  (logic_out),
    .cmp_out    (cmp_out),
    .shift_out  (shift_out),
    .carry_out  (carry_out),
    .arith_flag (arith_flag),
    .logic_flag (logic_flag),
    .cmp_flag   (cmp_flag),
    .shift_flag (shift_flag),
    .sel_data   (sel_data),
    .sel_flag   (sel_flag),
    .sel_carry  (sel_carry)
  );

`ifdef ALU_ISSUER_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       expire;
  logic       rsp_err_q;
`else
  // Parameter only matters when the wait bound is built.
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT_CYC);
`endif

  // State register; reset abandons any in-flight command silently.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and one-cycle strobes. Flags are ignored in ISSUE because
  // the ALU may still be presenting the previous operation's flag.
  always_comb begin
    state_d  = state_q;
    load_cmd = 1'b0;
    capture  = 1'b0;
`ifdef ALU_ISSUER_TIMEOUT_EN
    expire   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          load_cmd = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (sel_flag) begin
          capture = 1'b1;
          state_d = RESP;
        end
`ifdef ALU_ISSUER_TIMEOUT_EN
        else if (wait_cnt == 8'(TIMEOUT_CYC - 1)) begin
          expire  = 1'b1;
          state_d = RESP;
        end
`endif
      end
      default: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
    endcase
  end

  // Operand/function registers and captured response fields.
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_fun     <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_unit_q  <= '0;
    end else begin
      if (load_cmd) begin
        alu_a   <= bus.cmd_a;
        alu_b   <= bus.cmd_b;
        alu_fun <= bus.cmd_fun;
      end
      if (capture) begin
        rsp_data_q  <= sel_data;
        rsp_carry_q <= sel_carry;
        rsp_unit_q  <= unit_of(alu_fun);
      end
`ifdef ALU_ISSUER_TIMEOUT_EN
      if (expire) begin
        rsp_data_q  <= '0;
        rsp_carry_q <= 1'b0;
        rsp_unit_q  <= unit_of(alu_fun);
      end
`endif
    end
  end

`ifdef ALU_ISSUER_TIMEOUT_EN
  // Wait-cycle counter cleared on entry to WAIT; error flag for the response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)                wait_cnt <= '0;
      else if (state_q == WAIT && !sel_flag) wait_cnt <= wait_cnt + 8'd1;
      if (capture)     rsp_err_q <= 1'b0;
      else if (expire) rsp_err_q <= 1'b1;
    end
  end
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_unit  = rsp_unit_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Testbench for alu_cmd_issuer: behavioural ALU stub, transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_alu_cmd_issuer;

`ifdef ALU_ISSUER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TIMEOUT_CYC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic [15:0] arith_out = '0, logic_out = '0, cmp_out = '0, shift_out = '0;
  logic        carry_out = 1'b0;
  logic        arith_flag = 1'b0, logic_flag = 1'b0, cmp_flag = 1'b0, shift_flag = 1'b0;
  logic [1:0]  stub_mode = 2'd0;  // 0 normal, 1 shift flag stuck high, 2 cmp flag never
  int          checks = 0;
  int          failures = 0;
  bit          cmp_en = 1'b0;

  alu_cmd_issuer_if #(.Op_Width(16)) bus ();

  alu_cmd_issuer #(.Op_Width(16), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK(clk), .RST(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .carry_out(carry_out),
    .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag)
  );

  always #5 clk = ~clk;

  // ALU stub: results registered one cycle after inputs; selected flag high,
  // other flags random.
  always @(posedge clk) begin
    {carry_out, arith_out} <= {1'b0, alu_a} + {1'b0, alu_b};
    logic_out  <= alu_a ^ alu_b;
    cmp_out    <= alu_a ^ alu_b;
    shift_out  <= alu_a ^ alu_b;
    arith_flag <= (alu_fun[3:2] == 2'd0) || ($urandom_range(0, 1) == 1);
    logic_flag <= (alu_fun[3:2] == 2'd1) || ($urandom_range(0, 1) == 1);
    cmp_flag   <= (stub_mode != 2'd2) && ((alu_fun[3:2] == 2'd2) || ($urandom_range(0, 1) == 1));
    shift_flag <= (stub_mode == 2'd1) || (alu_fun[3:2] == 2'd3) || ($urandom_range(0, 1) == 1);
  end

  // Reference results from the operation definition.
  function automatic logic [15:0] exp_data(input logic [15:0] a, b, input logic [3:0] fun);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (fun[3:2] == 2'd0) ? s[15:0] : (a ^ b);
  endfunction
  function automatic logic exp_carry(input logic [15:0] a, b, input logic [3:0] fun);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (fun[3:2] == 2'd0) ? s[16] : 1'b0;
  endfunction

  // Transaction-level model: busy from accept until response consumed,
  // response appears a fixed number of edges after accept.
  logic        m_busy = 1'b0, m_rsp_valid = 1'b0, m_never = 1'b0;
  logic [15:0] m_alu_a = '0, m_alu_b = '0, m_data = '0;
  logic [3:0]  m_alu_fun = '0;
  logic        m_carry = 1'b0, m_err = 1'b0;
  logic [1:0]  m_unit = '0;
  int          m_age = 0, m_target = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_rsp_valid <= 1'b0; m_alu_a <= '0; m_alu_b <= '0; m_alu_fun <= '0;
      m_data <= '0; m_carry <= 1'b0; m_unit <= '0; m_err <= 1'b0; m_age <= 0;
    end else if (!m_busy) begin
      if (bus.cmd_valid) begin
        m_busy <= 1'b1; m_age <= 0;
        m_alu_a <= bus.cmd_a; m_alu_b <= bus.cmd_b; m_alu_fun <= bus.cmd_fun;
        m_never  <= (stub_mode == 2'd2);
        m_target <= (stub_mode == 2'd2) ? (TO_EN ? TIMEOUT_CYC + 1 : 32'h7fffffff) : 2;
      end
    end else if (!m_rsp_valid) begin
      m_age <= m_age + 1;
      if (m_age + 1 == m_target) begin
        m_rsp_valid <= 1'b1;
        m_unit      <= m_alu_fun[3:2];
        m_data      <= m_never ? 16'h0 : exp_data(m_alu_a, m_alu_b, m_alu_fun);
        m_carry     <= m_never ? 1'b0 : exp_carry(m_alu_a, m_alu_b, m_alu_fun);
        m_err       <= m_never;
      end
    end else if (bus.rsp_ready) begin
      m_rsp_valid <= 1'b0;
      m_busy      <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
      chk("alu_a",     32'(alu_a),         32'(m_alu_a));
      chk("alu_b",     32'(alu_b),         32'(m_alu_b));
      chk("alu_fun",   32'(alu_fun),       32'(m_alu_fun));
      chk("rsp_data",  32'(bus.rsp_data),  32'(m_data));
      chk("rsp_carry", 32'(bus.rsp_carry), 32'(m_carry));
      chk("rsp_unit",  32'(bus.rsp_unit),  32'(m_unit));
      chk("rsp_err",   32'(bus.rsp_err),   32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [15:0] a, b, input logic [3:0] fun, input logic [1:0] mode);
    stub_mode     = mode;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_fun   = fun;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Returns edges counted from the accept edge (inclusive) to rsp_valid.
  task automatic wait_rsp(output int lat);
    lat = 1;
    for (int i = 0; i < 40 && !bus.rsp_valid; i++) begin
      step();
      lat++;
    end
    if (!bus.rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL rsp_wait actual=no_rsp_valid expected=rsp_valid within 40 cycles");
    end
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  fun;
    logic [15:0] d;
    logic        c;
  } vec_t;
  vec_t vecs[4] = '{
    '{16'h8000, 16'h8000, 4'b0011, 16'h0000, 1'b1},
    '{16'h7FFF, 16'h0001, 4'b0001, 16'h8000, 1'b0},
    '{16'hA5A5, 16'h5A5A, 4'b0110, 16'hFFFF, 1'b0},
    '{16'h0F0F, 16'h0F0F, 4'b1001, 16'h0000, 1'b0}
  };

  initial begin
    int lat;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_fun = '0;
    bus.rsp_ready = 1'b1;
    step();
    cmp_en = 1'b1;
    step();
    rst = 1'b0;
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    step();

    // Arithmetic with carry-out.
    issue(16'hFFFF, 16'h0001, 4'b0000, 2'd0);
    wait_rsp(lat);
    chk("arith_latency", 32'(lat), 32'd3);
    chk("arith_data",    32'(bus.rsp_data),  32'h0000);
    chk("arith_carry",   32'(bus.rsp_carry), 32'd1);
    chk("arith_unit",    32'(bus.rsp_unit),  32'd0);
    chk("arith_err",     32'(bus.rsp_err),   32'd0);
    step();
    chk("arith_idle_after", 32'(bus.cmd_ready), 32'd1);

    // Logic unit; cmd_ready low from accept through the response.
    issue(16'h00F0, 16'h0FF0, 4'b0101, 2'd0);
    chk("logic_busy_ready", 32'(bus.cmd_ready), 32'd0);
    wait_rsp(lat);
    chk("logic_data",  32'(bus.rsp_data),  32'h0F00);
    chk("logic_carry", 32'(bus.rsp_carry), 32'd0);
    chk("logic_unit",  32'(bus.rsp_unit),  32'd1);
    chk("logic_rsp_ready", 32'(bus.cmd_ready), 32'd0);
    step();

    // Response backpressure with a pending command held off.
    bus.rsp_ready = 1'b0;
    issue(16'h1234, 16'h1111, 4'b0010, 2'd0);
    wait_rsp(lat);
    bus.cmd_a = 16'hDEAD; bus.cmd_b = 16'hBEEF; bus.cmd_fun = 4'b0100;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data",  32'(bus.rsp_data),  32'h2345);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    chk("bp_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    chk("bp_idle",        32'(bus.cmd_ready), 32'd1);
    chk("bp_not_taken",   32'(alu_a),         32'h1234);
    chk("bp_data_held",   32'(bus.rsp_data),  32'h2345);
    step();

    // Stale flag: shift flag stuck high must not cause early capture.
    issue(16'hFFFF, 16'h0000, 4'b1100, 2'd0);
    wait_rsp(lat);
    chk("shift_prev_data", 32'(bus.rsp_data), 32'hFFFF);
    step();
    issue(16'h1234, 16'h1230, 4'b1100, 2'd1);
    wait_rsp(lat);
    chk("stale_latency", 32'(lat), 32'd3);
    chk("stale_data",    32'(bus.rsp_data), 32'h0004);
    chk("stale_unit",    32'(bus.rsp_unit), 32'd3);
    step();
    stub_mode = 2'd0;

    // Table of further vectors.
    foreach (vecs[k]) begin
      issue(vecs[k].a, vecs[k].b, vecs[k].fun, 2'd0);
      wait_rsp(lat);
      chk("vec_data",  32'(bus.rsp_data),  32'(vecs[k].d));
      chk("vec_carry", 32'(bus.rsp_carry), 32'(vecs[k].c));
      step();
    end

    // Reset while waiting on a flag that never comes.
    issue(16'h0005, 16'h0003, 4'b1000, 2'd2);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_alu_a",     32'(alu_a),         32'd0);
    chk("rst_alu_b",     32'(alu_b),         32'd0);
    chk("rst_alu_fun",   32'(alu_fun),       32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    stub_mode = 2'd0;
    step();

    // Missing flag: error response when bounded, otherwise no response.
    issue(16'hAAAA, 16'h5555, 4'b1000, 2'd2);
`ifdef ALU_ISSUER_TIMEOUT_EN
    wait_rsp(lat);
    chk("to_latency", 32'(lat), 32'(TIMEOUT_CYC + 2));
    chk("to_err",     32'(bus.rsp_err),   32'd1);
    chk("to_data",    32'(bus.rsp_data),  32'h0000);
    chk("to_carry",   32'(bus.rsp_carry), 32'd0);
    step();
    chk("to_idle", 32'(bus.cmd_ready), 32'd1);
`else
    for (int i = 0; i < 100; i++) begin
      chk("nobound_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif
    stub_mode = 2'd0;
    step();

    // Recovery: normal op afterwards.
    issue(16'h0001, 16'h0002, 4'b0000, 2'd0);
    wait_rsp(lat);
    chk("recover_data", 32'(bus.rsp_data), 32'h0003);
    chk("recover_err",  32'(bus.rsp_err),  32'd0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Command-side initiator for ALU_TOP. It accepts one ALU command (A, B, ALU_FUN) per valid/ready handshake and drives the ALU operand/function inputs from registers. It waits for the flag of the unit selected by ALU_FUN[3:2], captures that unit's result (plus carry for arithmetic), and returns it on a valid/ready response port. It sits between a bus/host front end and ALU_TOP, with one command in flight at a time.

Parameters:
Op_Width, 16, operand/result width; must match ALU_TOP Op_Width
TIMEOUT_CYC, 8, max WAIT cycles before error response (used only with ALU_ISSUER_TIMEOUT_EN); range 1..255

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous active-high reset
cmd_valid  input  1  command valid
cmd_ready  output  1  issuer can accept a command
cmd_a  input  Op_Width  operand A
cmd_b  input  Op_Width  operand B
cmd_fun  input  4  ALU function; [3:2] unit select: 00 arith, 01 logic, 10 cmp, 11 shift
alu_a  output  Op_Width  registered A to ALU_TOP
alu_b  output  Op_Width  registered B to ALU_TOP
alu_fun  output  4  registered ALU_FUN to ALU_TOP
arith_out, logic_out, cmp_out, shift_out  input  Op_Width each  ALU_TOP results
carry_out  input  1  ALU_TOP carry
arith_flag, logic_flag, cmp_flag, shift_flag  input  1 each  ALU_TOP result-valid flags
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_data  output  Op_Width  captured result of selected unit
rsp_carry  output  1  captured carry_out (arith only, else 0)
rsp_unit  output  2  echo of cmd_fun[3:2]
rsp_err  output  1  timeout error (0 when feature compiled out)

Behaviour:
- Reset (RST high at rising edge): state IDLE; alu_a=0, alu_b=0, alu_fun=0; rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_unit=0, rsp_err=0; timeout counter=0. Reset aborts any in-flight command without a response.
- cmd_ready=1 only in IDLE; combinational from state only, never from cmd_valid.
- States:
  - IDLE: on cmd_valid&cmd_ready at edge E0, load alu_a/alu_b/alu_fun from cmd_*, go to ISSUE.
  - ISSUE: exactly one cycle. Flags are ignored here because they may be stale from a prior op. Go to WAIT.
  - WAIT: sample the flag selected by alu_fun[3:2]. If it is 1 at edge E, capture the matching *_out into rsp_data, capture rsp_carry=carry_out when unit=00 (else 0), set rsp_unit and rsp_err=0, go to RESP. Flags of non-selected units are ignored.
  - RESP: rsp_valid=1 and all rsp_* are held stable. On rsp_valid&rsp_ready, go to IDLE and clear rsp_valid at the same edge.
- Latency: with an ALU that flags one cycle after its inputs register, rsp_valid rises 3 edges after command acceptance (E0: accept; E1: ALU registers; E2: issuer captures; rsp_valid is visible after E2). Throughput is at best one command per 4 cycles with rsp_ready held high.
- alu_a/alu_b/alu_fun hold their last command values in all states until the next acceptance.
- A command cannot be accepted in the same cycle a response is consumed; the next accept is earliest in the cycle after RESP exits.
- rsp_* outputs hold their last values after handshake; only rsp_valid drops.

Optional Feature:
ALU_ISSUER_TIMEOUT_EN:
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle without the selected flag. When it reaches TIMEOUT_CYC, go to RESP with rsp_err=1, rsp_data=0, rsp_carry=0. If the flag and the limit occur in the same cycle, the flag wins (normal response).
- Undefined: WAIT has no bound, the counter is not built, and rsp_err is tied to 0.

Decomposition:
- Package alu_issuer_pkg: unit-select constants (UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11); state encoding IDLE/ISSUE/WAIT/RESP.
- One sub-module, alu_rsp_mux: combinational selection of result, flag and carry by unit code, reused by later ALU front ends.

Test Plan:
Bench uses a behavioural ALU stub: registered outputs one cycle after inputs; arith_out=A+B with carry; logic/cmp/shift_out=A^B; the flag of the selected unit is high one cycle after inputs, other flags random.
- Arith carry: cmd_fun=4'b0000, A=16'hFFFF, B=16'h0001, rsp_ready=1 -> rsp_valid 3 edges after accept, rsp_data=16'h0000, rsp_carry=1, rsp_unit=0, rsp_err=0.
- Logic unit: cmd_fun=4'b0101, A=16'h00F0, B=16'h0FF0 -> rsp_data=16'h0F00, rsp_carry=0, rsp_unit=1; cmd_ready=0 from accept through response handshake.
- Response backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_data stable, cmd_ready=0, a pending cmd_valid is not accepted; rsp_ready=1 -> IDLE next cycle.
- Stale flag: stub holds shift_flag=1 continuously while the flag lags by 2 cycles for cmd_fun=4'b1100 -> capture only after ISSUE, result matches new operands.
- Reset mid-operation: RST=1 in WAIT -> next cycle IDLE, rsp_valid=0, alu_a=alu_b=0, alu_fun=0, cmd_ready=1.
- Timeout (ALU_ISSUER_TIMEOUT_EN, TIMEOUT_CYC=8): stub never raises cmp_flag for cmd_fun=4'b1000 -> RESP after 8 WAIT cycles, rsp_err=1, rsp_data=0; with the macro undefined, rsp_valid stays 0 for 100 cycles.
